// File: rtl/move_scheduler_if.sv
// Action channel between the move scheduler and the board engine.
// One action is transferred on each edge where act_valid and act_ready are both high.
interface move_scheduler_if;
  logic       act_valid;
  logic       act_ready;
  logic [2:0] act_code;

  // Scheduler side: offers actions
  modport master (
    output act_valid,
    output act_code,
    input  act_ready
  );

  // Board-engine side: accepts actions
  modport slave (
    input  act_valid,
    input  act_code,
    output act_ready
  );
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: turns the sampled keyboard keycode and the per-frame tick into a
// serialized stream of piece actions. It implements delayed auto-shift and
// auto-repeat for left/right, repeating soft drop, and a programmable gravity timer.
// Requests collect in a one-bit-per-action pending register. A fixed-priority
// two-state offer FSM drains that register through a valid/ready channel.
module move_scheduler #(
  parameter int DAS_FRAMES  = 10,
  parameter int ARR_FRAMES  = 2,
  parameter int SOFT_FRAMES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [7:0]       keycode,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic [5:0]       gravity_period,
  move_scheduler_if.master act
);

  // Counter width covers the largest frame parameter, including the terminal value.
  localparam int MAX_AR = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
  localparam int MAX_F  = (MAX_AR > SOFT_FRAMES) ? MAX_AR : SOFT_FRAMES;
  localparam int CNT_W  = $clog2(MAX_F + 1);

  localparam logic [CNT_W-1:0] DAS_C  = CNT_W'(DAS_FRAMES);
  localparam logic [CNT_W-1:0] ARR_C  = CNT_W'(ARR_FRAMES);
  localparam logic [CNT_W-1:0] SOFT_C = CNT_W'(SOFT_FRAMES);

  // USB HID keycodes of the mapped keys
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  // Pending-bit index is (action code - 1)
  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_ROT   = 2;
  localparam int B_SOFT  = 3;
  localparam int B_HARD  = 4;
  localparam int B_GRAV  = 5;

  localparam logic [5:0] HARD_ONLY = 6'b01_0000;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  // Fixed priority: hard > rotate > left > right > soft > gravity
  function automatic logic [2:0] pick_action(input logic [5:0] p);
    logic [2:0] c;
    if      (p[B_HARD])  c = 3'd5;
    else if (p[B_ROT])   c = 3'd3;
    else if (p[B_LEFT])  c = 3'd1;
    else if (p[B_RIGHT]) c = 3'd2;
    else if (p[B_SOFT])  c = 3'd4;
    else if (p[B_GRAV])  c = 3'd6;
    else                 c = 3'd0;
    return c;
  endfunction

  // One-hot pending mask for an action code (code 0 maps to no bit)
  function automatic logic [5:0] code_mask(input logic [2:0] c);
    logic [5:0] m;
    if (c == 3'd0) m = 6'd0;
    else           m = 6'd1 << (c - 3'd1);
    return m;
  endfunction

  // Registered state
  logic [7:0]       prev_key_q;
  logic [CNT_W-1:0] das_q, das_d;
  logic [CNT_W-1:0] arr_q, arr_d;
  logic             rep_q, rep_d;
  logic [5:0]       grav_q, grav_d;
  logic [5:0]       pend_q, pend_d;
  state_t           state_q, state_d;
  logic [2:0]       code_q, code_d;

  // Combinational helpers
  logic [5:0] req;
  logic [5:0] gp_eff;
  logic [6:0] grav_inc;
  logic       key_same;
  logic       key_lr;
  logic       xfer;
  logic [5:0] offer_mask;

  assign gp_eff     = (gravity_period == 6'd0) ? 6'd1 : gravity_period;
  assign grav_inc   = {1'b0, grav_q} + 7'd1;
  assign key_same   = (keycode == prev_key_q);
  assign key_lr     = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT);
  assign xfer       = (state_q == S_OFFER) && act.act_ready;
  assign offer_mask = (state_q == S_OFFER) ? code_mask(code_q) : 6'd0;

  // Per-tick request generation: key press / DAS / ARR / soft repeat and gravity timer
  always_comb begin
    req    = 6'd0;
    das_d  = das_q;
    arr_d  = arr_q;
    rep_d  = rep_q;
    grav_d = grav_q;
    if (frame_tick && enable) begin
      if (!key_same) begin
        // A change to a mapped key is a press; a change to anything else only
        // arms the next press. Counters restart on every press.
        case (keycode)
          KEY_LEFT:  req[B_LEFT]  = 1'b1;
          KEY_RIGHT: req[B_RIGHT] = 1'b1;
          KEY_UP:    req[B_ROT]   = 1'b1;
          KEY_DOWN:  req[B_SOFT]  = 1'b1;
          KEY_SPACE: req[B_HARD]  = 1'b1;
          default:   req          = 6'd0;
        endcase
        if (req != 6'd0) begin
          das_d = '0;
          arr_d = '0;
          rep_d = 1'b0;
        end
      end else if (key_lr) begin
        if (!rep_q) begin
          das_d = das_q + 1'b1;
          if (das_d == DAS_C) begin
            req[B_LEFT]  = (keycode == KEY_LEFT);
            req[B_RIGHT] = (keycode == KEY_RIGHT);
            rep_d        = 1'b1;
            arr_d        = '0;
          end
        end else begin
          arr_d = arr_q + 1'b1;
          if (arr_d == ARR_C) begin
            req[B_LEFT]  = (keycode == KEY_LEFT);
            req[B_RIGHT] = (keycode == KEY_RIGHT);
            arr_d        = '0;
          end
        end
      end else if (keycode == KEY_DOWN) begin
        // Held Down reuses the repeat counter for its soft-drop cadence
        arr_d = arr_q + 1'b1;
        if (arr_d == SOFT_C) begin
          req[B_SOFT] = 1'b1;
          arr_d       = '0;
        end
      end

      // A soft drop already moves the piece down, so it restarts the gravity timer
      if (req[B_SOFT]) begin
        grav_d = 6'd0;
      end else if (grav_inc >= {1'b0, gp_eff}) begin
        req[B_GRAV] = 1'b1;
        grav_d      = 6'd0;
      end else begin
        grav_d = grav_inc[5:0];
      end
    end
  end

  // Pending register: retire the issued bit first, then merge this tick's requests
  always_comb begin
    pend_d = pend_q;
    if (xfer) pend_d = pend_d & ~offer_mask;
    if (enable) begin
      if (req[B_HARD]) pend_d = HARD_ONLY;
      else             pend_d = pend_d | req;
    end else begin
      // Paused: keep only the action already on the channel
      pend_d = pend_d & offer_mask;
    end
  end

  // Offer FSM next state: pick the top pending action, hold it until accepted
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (enable && (pend_q != 6'd0)) begin
          state_d = S_OFFER;
          code_d  = pick_action(pend_q);
        end
      end
      S_OFFER: begin
        if (act.act_ready) begin
          state_d = S_IDLE;
          code_d  = 3'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        code_d  = 3'd0;
      end
    endcase
  end

  // Key history, counters and pending bits
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_key_q <= 8'h00;
      das_q      <= '0;
      arr_q      <= '0;
      rep_q      <= 1'b0;
      grav_q     <= 6'd0;
      pend_q     <= 6'd0;
    end else begin
      // prev_key follows every tick, even while paused, so a held key is not a new press
      if (frame_tick) prev_key_q <= keycode;
      das_q  <= das_d;
      arr_q  <= arr_d;
      rep_q  <= rep_d;
      grav_q <= grav_d;
      pend_q <= pend_d;
    end
  end

  // Offer FSM state and registered action code
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign act.act_valid = (state_q == S_OFFER);
  assign act.act_code  = code_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Testbench for move_scheduler: table-driven key/gravity scenarios, hand-written
// handshake corner cases, and a randomized run against a behavioural model.
module tb_move_scheduler;
  localparam int DAS  = 10;
  localparam int ARR  = 2;
  localparam int SOFT = 2;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       enable;
  logic [5:0] gravity_period;

  move_scheduler_if act_if ();

  move_scheduler #(
    .DAS_FRAMES (DAS),
    .ARR_FRAMES (ARR),
    .SOFT_FRAMES(SOFT)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .keycode       (keycode),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .gravity_period(gravity_period),
    .act           (act_if)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cur_tick = 0;
  bit model_on = 1'b0;

  // Transfer log for the directed tests
  int log_code[$];
  int log_cyc[$];
  int log_tick[$];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Reset_n && act_if.act_valid && act_if.act_ready) begin
      log_code.push_back(int'(act_if.act_code));
      log_cyc.push_back(cyc);
      log_tick.push_back(cur_tick);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n        = 1'b0;
    keycode        = 8'h00;
    frame_tick     = 1'b0;
    enable         = 1'b1;
    act_if.act_ready = 1'b1;
    gravity_period = 6'd63;
    step();
    step();
    Reset_n = 1'b1;
    step();
  endtask

  task automatic tick(input logic [7:0] k);
    keycode    = k;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic clear_log();
    log_code.delete();
    log_cyc.delete();
    log_tick.delete();
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_prev;
  int         m_das, m_arr, m_grav, m_offer;
  bit         m_rep;
  bit         m_pend[1:6];

  function automatic int key_act(input logic [7:0] k);
    case (k)
      8'h50:   return 1;
      8'h4F:   return 2;
      8'h52:   return 3;
      8'h51:   return 4;
      8'h2C:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = 8'h00; m_das = 0; m_arr = 0; m_grav = 0; m_rep = 1'b0; m_offer = 0;
    for (int i = 1; i <= 6; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step();
    bit req[1:6];
    int a, gp, nxt;
    int prio[6] = '{5, 3, 1, 2, 4, 6};
    bit xfer;
    for (int i = 1; i <= 6; i++) req[i] = 1'b0;
    xfer = (m_offer != 0) && act_if.act_ready;
    a = key_act(keycode);
    if (frame_tick && enable) begin
      if (keycode != m_prev && a != 0) begin
        req[a] = 1'b1; m_das = 0; m_arr = 0; m_rep = 1'b0;
      end else if (keycode == m_prev && (a == 1 || a == 2)) begin
        if (!m_rep) begin
          m_das++;
          if (m_das == DAS) begin req[a] = 1'b1; m_rep = 1'b1; m_arr = 0; end
        end else begin
          m_arr++;
          if (m_arr == ARR) begin req[a] = 1'b1; m_arr = 0; end
        end
      end else if (keycode == m_prev && a == 4) begin
        m_arr++;
        if (m_arr == SOFT) begin req[4] = 1'b1; m_arr = 0; end
      end
      gp = (gravity_period == 0) ? 1 : int'(gravity_period);
      if (req[4]) m_grav = 0;
      else if (m_grav + 1 >= gp) begin req[6] = 1'b1; m_grav = 0; end
      else m_grav++;
    end
    if (frame_tick) m_prev = keycode;
    nxt = m_offer;
    if (m_offer == 0) begin
      if (enable)
        for (int i = 0; i < 6; i++)
          if (nxt == 0 && m_pend[prio[i]]) nxt = prio[i];
    end else if (xfer) begin
      nxt = 0;
    end
    if (xfer) m_pend[m_offer] = 1'b0;
    if (enable) begin
      if (req[5]) begin
        for (int i = 1; i <= 6; i++) m_pend[i] = 1'b0;
        m_pend[5] = 1'b1;
      end else begin
        for (int i = 1; i <= 6; i++) m_pend[i] = m_pend[i] | req[i];
      end
    end else begin
      for (int i = 1; i <= 6; i++) if (i != m_offer) m_pend[i] = 1'b0;
    end
    m_offer = nxt;
  endtask

  always @(posedge Clk) if (model_on) model_step();

  always @(negedge Clk) begin
    if (model_on) begin
      check("rand_valid", int'(act_if.act_valid), (m_offer != 0) ? 1 : 0);
      if (m_offer != 0) check("rand_code", int'(act_if.act_code), m_offer);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [5:0]  gp;
    logic [7:0]  key;
    int          start;
    int          len;
    int          nticks;
    logic [2:0]  code;
    logic [31:0] mask;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mask;
    int hold_moves;

    // Expected mask: bit t set when the action for tick t is issued
    vecs[0]  = '{6'd63, 8'h50, 0, 1,  5,  3'd1, 32'h0000_0001}; // left tap
    vecs[1]  = '{6'd63, 8'h50, 0, 20, 22, 3'd1, 32'h0005_5401}; // left hold: 0,10,12,14,16,18
    vecs[2]  = '{6'd63, 8'h4F, 0, 12, 14, 3'd2, 32'h0000_0401}; // right hold: 0,10
    vecs[3]  = '{6'd3,  8'h00, 0, 0,  10, 3'd6, 32'h0000_0124}; // gravity 2,5,8
    vecs[4]  = '{6'd3,  8'h51, 4, 1,  10, 3'd6, 32'h0000_0084}; // gravity 2,7 after soft at 4
    vecs[5]  = '{6'd3,  8'h51, 4, 1,  10, 3'd4, 32'h0000_0010}; // soft at 4
    vecs[6]  = '{6'd63, 8'h51, 0, 6,  8,  3'd4, 32'h0000_0015}; // soft hold: 0,2,4
    vecs[7]  = '{6'd63, 8'h52, 0, 6,  8,  3'd3, 32'h0000_0001}; // rotate no repeat
    vecs[8]  = '{6'd63, 8'h2C, 0, 6,  8,  3'd5, 32'h0000_0001}; // hard no repeat
    vecs[9]  = '{6'd63, 8'h04, 0, 6,  8,  3'd1, 32'h0000_0000}; // unmapped key
    vecs[10] = '{6'd0,  8'h00, 0, 0,  4,  3'd6, 32'h0000_000F}; // period 0 acts as 1
    vecs[11] = '{6'd1,  8'h50, 0, 11, 12, 3'd1, 32'h0000_0401}; // left with gravity every tick

    do_reset();
    check("reset_valid", int'(act_if.act_valid), 0);
    check("reset_code",  int'(act_if.act_code), 0);

    for (int v = 0; v < 12; v++) begin
      do_reset();
      check($sformatf("vec%0d_reset_valid", v), int'(act_if.act_valid), 0);
      gravity_period = vecs[v].gp;
      clear_log();
      for (int t = 0; t < vecs[v].nticks; t++) begin
        cur_tick = t;
        tick((t >= vecs[v].start && t < vecs[v].start + vecs[v].len) ? vecs[v].key : 8'h00);
        repeat (7) step();
      end
      mask = 0;
      foreach (log_code[i]) if (log_code[i] == int'(vecs[v].code)) mask |= (1 << log_tick[i]);
      check($sformatf("vec%0d_code%0d_ticks", v, vecs[v].code), mask, int'(vecs[v].mask));
    end

    // Back-pressure: hard already on the channel, rotate and left merge behind it
    do_reset();
    act_if.act_ready = 1'b0;
    clear_log();
    tick(8'h2C); repeat (3) step();
    tick(8'h52); repeat (3) step();
    tick(8'h50); repeat (3) step();
    tick(8'h00); repeat (3) step();
    check("bp_held_valid", int'(act_if.act_valid), 1);
    check("bp_held_code",  int'(act_if.act_code), 5);
    check("bp_no_xfer",    log_code.size(), 0);
    act_if.act_ready = 1'b1;
    repeat (12) step();
    check("bp_xfer_count", log_code.size(), 3);
    if (log_code.size() == 3) begin
      check("bp_order0", log_code[0], 5);
      check("bp_order1", log_code[1], 3);
      check("bp_order2", log_code[2], 1);
      check("bp_gap1", log_cyc[1] - log_cyc[0], 2);
      check("bp_gap2", log_cyc[2] - log_cyc[1], 2);
    end

    // Coincident tick on a gravity transfer edge: the fresh gravity request survives
    do_reset();
    gravity_period = 6'd1;
    clear_log();
    frame_tick = 1'b1; step();   // tick: gravity pending
    frame_tick = 1'b0; step();   // offer raised
    frame_tick = 1'b1; step();   // transfer edge plus new tick
    frame_tick = 1'b0;
    repeat (6) step();
    check("coinc_count", log_code.size(), 2);
    if (log_code.size() == 2) begin
      check("coinc_code", log_code[1], 6);
      check("coinc_gap",  log_cyc[1] - log_cyc[0], 2);
    end

    // Pause: in-flight offer completes, pending is dropped, counters freeze
    do_reset();
    act_if.act_ready = 1'b0;
    clear_log();
    tick(8'h50); repeat (3) step();
    tick(8'h4F); repeat (3) step();   // right pending behind left
    enable = 1'b0;
    step(); step();
    act_if.act_ready = 1'b1;
    repeat (10) step();
    check("pause_xfers", log_code.size(), 1);
    if (log_code.size() == 1) check("pause_code", log_code[0], 1);
    check("pause_idle", int'(act_if.act_valid), 0);
    for (int t = 0; t < 15; t++) begin tick(8'h4F); repeat (3) step(); end
    check("pause_no_offer", log_code.size(), 1);
    enable = 1'b1;
    clear_log();
    for (int t = 0; t < 9; t++) begin tick(8'h4F); repeat (3) step(); end
    check("resume_no_press", log_code.size(), 0);
    tick(8'h4F); repeat (5) step();
    hold_moves = 0;
    foreach (log_code[i]) if (log_code[i] == 2) hold_moves++;
    check("resume_das_frozen", hold_moves, 1);

    // Asynchronous reset aborts an offer mid-handshake
    do_reset();
    act_if.act_ready = 1'b0;
    tick(8'h50); step(); step();
    check("arst_pre_valid", int'(act_if.act_valid), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_valid", int'(act_if.act_valid), 0);
    check("arst_code",  int'(act_if.act_code), 0);
    step();
    Reset_n = 1'b1;
    step();

    // Randomized run against the behavioural model
    begin
      logic [7:0] keys[7] = '{8'h00, 8'h50, 8'h4F, 8'h51, 8'h52, 8'h2C, 8'h04};
      logic [5:0] gps[6]  = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd7};
      logic [7:0] cur_key;
      do_reset();
      gravity_period = 6'd3;
      cur_key = 8'h00;
      model_reset();
      model_on = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        frame_tick = ($urandom_range(0, 3) == 0);
        if (frame_tick && $urandom_range(0, 23) == 0) cur_key = keys[$urandom_range(0, 6)];
        keycode = frame_tick ? cur_key : 8'($urandom);
        act_if.act_ready = ($urandom_range(0, 3) != 0);
        if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
        else if (!enable && $urandom_range(0, 29) == 0) enable = 1'b1;
        if ($urandom_range(0, 499) == 0) gravity_period = gps[$urandom_range(0, 5)];
        step();
      end
      model_on = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
